// File: rtl/decode_stage.sv
// Registered instruction-decode stage: combinational decode into a 2-entry skid
// buffer, with halt/resume sequencing, flush, illegal detection and soft-reset pulse.
module decode_stage #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned REG_W   = 3,
    parameter int unsigned FUNC_W  = 3
) (
    input  logic                 clk_pi,
    input  logic                 reset_pi,
    input  logic                 instr_valid_pi,
    input  logic [INSTR_W-1:0]   instr_pi,
    output logic                 instr_ready_po,
    output logic                 dec_valid_po,
    input  logic                 dec_ready_pi,
    output logic [17:0]          ctrl_po,
    output logic [FUNC_W-1:0]    alu_func_po,
    output logic [REG_W-1:0]     dest_reg_po,
    output logic [REG_W-1:0]     src_reg1_po,
    output logic [REG_W-1:0]     src_reg2_po,
    output logic [INSTR_W-5:0]   immediate_po,
    input  logic                 flush_pi,
    input  logic                 resume_pi,
    output logic                 halted_po,
    output logic                 soft_rst_po
);

    localparam int unsigned IMM_W = INSTR_W - 4;

    // RESET command immediate: 1010... starting at the immediate MSB
    function automatic logic [IMM_W-1:0] alt_pattern();
        logic [IMM_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < IMM_W; i++) p[i] = ((IMM_W - 1 - i) % 2) == 0;
        return p;
    endfunction

    localparam logic [IMM_W-1:0] RST_IMM = alt_pattern();

    typedef struct packed {
        logic [17:0]        ctrl;
        logic [FUNC_W-1:0]  func;
        logic [REG_W-1:0]   dest;
        logic [REG_W-1:0]   src1;
        logic [REG_W-1:0]   src2;
        logic [IMM_W-1:0]   imm;
    } bundle_t;

    typedef enum logic {RUN, HALTED} state_t;

    state_t     state_q, state_d;
    bundle_t    dec;
    bundle_t    mem_q [2];
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, wr_ptr_q;
    logic       soft_rst_q;
    logic       push, pop;

    logic [3:0]       opcode;
    logic [REG_W-1:0] f0, f1, f2;
    logic [IMM_W-1:0] imm;

    assign opcode = instr_pi[INSTR_W-1 -: 4];
    assign f0     = instr_pi[INSTR_W-5 -: REG_W];
    assign f1     = instr_pi[INSTR_W-5-REG_W -: REG_W];
    assign f2     = instr_pi[INSTR_W-5-2*REG_W -: REG_W];
    assign imm    = instr_pi[IMM_W-1:0];

    always_comb begin
        dec      = '0;
        dec.func = instr_pi[FUNC_W-1:0];
        dec.dest = f0;
        dec.src1 = f1;
        dec.src2 = f2;
        dec.imm  = imm;
        unique case (opcode)
            4'd0:  ;
            4'd1:  dec.ctrl[0] = 1'b1;
            4'd2:  dec.ctrl[1] = 1'b1;
            4'd3:  begin
                if (instr_pi[INSTR_W-5-REG_W]) dec.ctrl[3] = 1'b1;
                else                           dec.ctrl[2] = 1'b1;
            end
            4'd4:  dec.ctrl[4] = 1'b1;
            4'd5:  dec.ctrl[5] = 1'b1;
            4'd6:  dec.ctrl[6] = 1'b1;
            4'd7:  dec.ctrl[7] = 1'b1;
            4'd8, 4'd9, 4'd10: begin
                dec.ctrl[opcode] = 1'b1;
                dec.src1 = f0;
                dec.src2 = f1;
            end
            4'd11: begin
                dec.ctrl[11] = 1'b1;
                dec.src1 = '0;
                dec.src2 = '0;
            end
            4'd12: dec.ctrl[12] = 1'b1;
            4'd15: begin
                if      (imm == IMM_W'(1)) dec.ctrl[13] = 1'b1;
                else if (imm == IMM_W'(2)) dec.ctrl[14] = 1'b1;
                else if (imm == '1)        dec.ctrl[15] = 1'b1;
                else if (imm == RST_IMM)   dec.ctrl[16] = 1'b1;
                else                       dec.ctrl[17] = 1'b1;
            end
            default: dec.ctrl[17] = 1'b1;
        endcase
    end

    assign instr_ready_po = (state_q == RUN) && (count_q < 2'd2);
    assign dec_valid_po   = (count_q != 2'd0);
    assign push           = instr_valid_pi & instr_ready_po & ~flush_pi;
    assign pop            = dec_valid_po & dec_ready_pi;

    always_comb begin
        count_d = count_q + 2'(push) - 2'(pop);
        if (flush_pi) count_d = '0;
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            soft_rst_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            soft_rst_q <= pop & mem_q[rd_ptr_q].ctrl[16];
            if (push) mem_q[wr_ptr_q] <= dec;
            if (flush_pi) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) state_q <= RUN;
        else          state_q <= state_d;
    end

    // push already excludes flush, so a discarded HALT never halts the stage
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (push && dec.ctrl[15]) state_d = HALTED;
            HALTED: if (resume_pi)            state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign halted_po    = (state_q == HALTED);
    assign soft_rst_po  = soft_rst_q;
    assign ctrl_po      = mem_q[rd_ptr_q].ctrl;
    assign alu_func_po  = mem_q[rd_ptr_q].func;
    assign dest_reg_po  = mem_q[rd_ptr_q].dest;
    assign src_reg1_po  = mem_q[rd_ptr_q].src1;
    assign src_reg2_po  = mem_q[rd_ptr_q].src2;
    assign immediate_po = mem_q[rd_ptr_q].imm;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus random traffic,
// checked at the falling edge against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [17:0] ctrl;
    logic [2:0]  alu_func, dest_reg, src1, src2;
    logic [11:0] immediate;
    logic        flush = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic        soft_rst;

    always #5 clk = ~clk;

    decode_stage #(.INSTR_W(16), .REG_W(3), .FUNC_W(3)) dut (
        .clk_pi(clk), .reset_pi(reset),
        .instr_valid_pi(instr_valid), .instr_pi(instr), .instr_ready_po(instr_ready),
        .dec_valid_po(dec_valid), .dec_ready_pi(dec_ready),
        .ctrl_po(ctrl), .alu_func_po(alu_func), .dest_reg_po(dest_reg),
        .src_reg1_po(src1), .src_reg2_po(src2), .immediate_po(immediate),
        .flush_pi(flush), .resume_pi(resume), .halted_po(halted), .soft_rst_po(soft_rst)
    );

    typedef struct packed {
        logic [17:0] ctrl;
        logic [2:0]  func;
        logic [2:0]  dest;
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic [11:0] imm;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic m_halted = 1'b0;
    logic m_soft = 1'b0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Class bit index follows from the opcode number; only MOVI and CONTROL need sub-decoding.
    function automatic exp_t model(input logic [15:0] ins);
        exp_t e;
        int   op, bitn;
        int   im;
        op   = int'(ins >> 12);
        im   = int'(ins & 16'h0FFF);
        e.func = ins[2:0];
        e.dest = 3'((ins >> 9) & 16'd7);
        e.src1 = 3'((ins >> 6) & 16'd7);
        e.src2 = 3'((ins >> 3) & 16'd7);
        e.imm  = 12'(im);
        bitn = -1;
        if (op == 1 || op == 2)          bitn = op - 1;
        else if (op == 3)                bitn = 2 + int'((ins >> 8) & 16'd1);
        else if (op >= 4 && op <= 12)    bitn = op;
        else if (op == 13 || op == 14)   bitn = 17;
        else if (op == 15) begin
            if      (im == 1)      bitn = 13;
            else if (im == 2)      bitn = 14;
            else if (im == 'hFFF)  bitn = 15;
            else if (im == 'hAAA)  bitn = 16;
            else                   bitn = 17;
        end
        if (op >= 8 && op <= 10) begin
            e.src1 = e.dest;
            e.src2 = 3'((ins >> 6) & 16'd7);
        end
        if (op == 11) begin
            e.src1 = 3'd0;
            e.src2 = 3'd0;
        end
        e.ctrl = (bitn < 0) ? 18'd0 : (18'd1 << bitn);
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic m_rdy, m_soft_n, halted_before;
            exp_t got;
            m_rdy = !m_halted && (q.size() < 2);
            halted_before = m_halted;
            chk("dec_valid", 64'(dec_valid), 64'(q.size() != 0));
            chk("instr_ready", 64'(instr_ready), 64'(m_rdy));
            chk("halted", 64'(halted), 64'(m_halted));
            chk("soft_rst", 64'(soft_rst), 64'(m_soft));
            got = {ctrl, alu_func, dest_reg, src1, src2, immediate};
            m_soft_n = 1'b0;
            if (q.size() != 0) begin
                chk("bundle", 64'(got), 64'(q[0]));
                if (dec_ready) begin
                    m_soft_n = q[0].ctrl[16];
                    void'(q.pop_front());
                end
            end
            if (flush) q.delete();
            else if (instr_valid && m_rdy) begin
                q.push_back(model(instr));
                if (instr == 16'hFFFF) m_halted = 1'b1;
            end
            if (halted_before && resume) m_halted = 1'b0;
            m_soft = m_soft_n;
            if (reset) begin
                q.delete();
                m_halted = 1'b0;
                m_soft   = 1'b0;
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] ins, input logic rdy,
                       input logic fl = 1'b0, input logic res = 1'b0);
        instr_valid = v;
        instr       = ins;
        dec_ready   = rdy;
        flush       = fl;
        resume      = res;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_ctrl", 64'(ctrl), 64'd0);
        chk("rst_fields", 64'({alu_func, dest_reg, src1, src2, immediate}), 64'd0);
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_ready", 64'(instr_ready), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_soft", 64'(soft_rst), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        reset = 1'b0;
        check_reset_state();

        // basic decode
        cyc(1'b1, 16'h1298, 1'b1);
        cyc(1'b1, 16'h8940, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        // MOVI, illegal and control
        cyc(1'b1, 16'h3507, 1'b1);
        cyc(1'b1, 16'hD000, 1'b1);
        cyc(1'b1, 16'hF123, 1'b1);
        cyc(1'b1, 16'hF001, 1'b1);
        cyc(1'b1, 16'hF002, 1'b1);
        cyc(1'b1, 16'hB1FF, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        // backpressure
        cyc(1'b1, 16'h4111, 1'b0);
        cyc(1'b1, 16'h5222, 1'b0);
        cyc(1'b1, 16'h6333, 1'b0);
        cyc(1'b1, 16'h7444, 1'b0);
        repeat (4) cyc(1'b0, 16'h0, 1'b1);
        // halt then resume
        cyc(1'b1, 16'hFFFF, 1'b1);
        cyc(1'b1, 16'h1111, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h2222, 1'b1);
        // flush discarding an accepted HALT
        cyc(1'b1, 16'h9999, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0);
        // soft reset pulse
        cyc(1'b1, 16'hFAAA, 1'b1);
        repeat (3) cyc(1'b0, 16'h0, 1'b1);
        // hard reset while halted with a full buffer
        cyc(1'b1, 16'h1234, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        reset = 1'b0;
        check_reset_state();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            r = 16'($urandom);
            if (r[15:12] == 4'hF) begin
                case ($urandom_range(0, 4))
                    0: r[11:0] = 12'h001;
                    1: r[11:0] = 12'h002;
                    2: r[11:0] = 12'hFFF;
                    3: r[11:0] = 12'hAAA;
                    default: ;
                endcase
            end
            cyc(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 4) == 0));
        end

        // drain
        for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
